display_sched: RTL and testbench
================================

# display_sched

Scheduler that shares the two-digit seven-segment display between up to four 8-bit debug sources of the CPU (for example PC, data pointer, current cell, last output byte). It rotates through the enabled sources on a fixed dwell time and supports a pin/freeze input. A one-shot flash override shows a source immediately when that source is written. Its `disp_byte` output drives the `din` input of the seven-segment multiplexing controller.

## Interface
- `DWELL`, default 12_000_000: cycles each source is shown during rotation; ≥ 2.
- `FLASH`, default 6_000_000: cycles a flashed source is held; ≥ 2.
- `CLK`  in  1: single clock; all state changes on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `src_data`  in  32: source i is byte `src_data[8i+7:8i]`, i = 0..3.
- `src_en`  in  4: rotation eligibility mask, one bit per source.
- `flash_req`  in  4: per-source one-cycle request to display that source now.
- `pin`  in  1: level; while high, rotation dwell does not advance.
- `disp_byte`  out  8: registered byte to the seven-segment controller.
- `disp_sel`  out  2: index of the source currently shown.
- `flashing`  out  1: high while in FLASH.

## Operation
- States: IDLE (no source enabled), ROTATE, FLASH.
- Internal registers:
  - `dwell_cnt`, width clog2(DWELL).
  - `flash_cnt`, width clog2(FLASH).
  - `rot_sel` (2 b), the rotation index saved across a flash.
- Reset:
  - State ROTATE if `src_en != 0`, otherwise IDLE.
  - `disp_sel = 0`, `rot_sel = 0`, `disp_byte = 0x00`, `flashing = 0`, both counters 0.
- Priority, highest first: `RST` > any `flash_req` bit > current source disabled > dwell expiry.
- Flash entry (from any state): `f` = lowest set bit of `flash_req`.
  - State ← FLASH, `disp_sel` ← f, `flash_cnt` ← 0.
  - Entry from ROTATE saves `rot_sel` ← `disp_sel`.
  - Entry from FLASH is a retrigger: `rot_sel` is unchanged and the count restarts.
  - Flash ignores `src_en` and `pin`.
- FLASH: `flash_cnt` increments each cycle. At `flash_cnt == FLASH-1` with no new request, leave FLASH:
  - If `src_en == 0`, go to IDLE.
  - Else go to ROTATE with `dwell_cnt` ← 0 and `disp_sel` ← `rot_sel` if that source is still enabled, otherwise the next enabled index.
- ROTATE:
  - If `src_en == 0`, go to IDLE.
  - Else if `src_en[disp_sel] == 0`, advance immediately to the next enabled index and set `dwell_cnt` ← 0. This applies regardless of `pin`.
  - Else if `pin`, hold `dwell_cnt` and `disp_sel`.
  - Else `dwell_cnt` increments. At `DWELL-1`, `dwell_cnt` ← 0 and `disp_sel` ← next enabled index.
- Next enabled index: search circularly i+1, i+2, i+3, then i itself. If only one source is enabled, the selection stays.
- IDLE:
  - `disp_byte = 0x00`; `disp_sel` holds its value; counters are 0.
  - When `src_en != 0`, go to ROTATE with `disp_sel` ← lowest enabled index.
- `disp_byte`: on every edge it loads the byte of `src_data` at the `disp_sel` value being loaded on that same edge. It loads 0x00 when the next state is IDLE. `disp_sel` and `disp_byte` are therefore always mutually consistent.
- `flashing` is registered and equals (next state == FLASH).

## Timing
- Source data change → `disp_byte` change: 1 cycle, and it continues to track each cycle while that source is selected.
- `flash_req` at edge t → `disp_sel`, `disp_byte`, `flashing` updated at edge t.
- Flash lasts exactly FLASH cycles after the last request. Rotation then resumes with a full DWELL.
- An unpinned source is shown for exactly DWELL cycles.
- Deasserting `pin` resumes counting from the held `dwell_cnt`; it does not restart the count.
- `RST` asserted mid-flash or mid-dwell takes effect at the next edge and overrides all other inputs that cycle.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
Each scenario uses `DWELL=4`, `FLASH=3`.

- **Reset and rotation.** Stimulus: `RST`, then `src_en=4'b1111`, `src_data=0x44332211`. Required: `disp_byte` 0x11, 0x22, 0x33, 0x44, 0x11, each held for 4 cycles, with `disp_sel` 0..3 in step.
- **Skip and disable.** Stimulus: `src_en=4'b1010`. Required: sel alternates 1 and 3. Clearing bit 3 while sel=3 gives sel=1 on the next edge. `src_en=0` gives `disp_byte=0x00` (IDLE).
- **Flash and retrigger.** Stimulus: in ROTATE at sel=1, `flash_req=4'b1100`. Required: sel=2 with `flashing=1`. A second `flash_req=4'b0001` one cycle later gives sel=0, which holds for 3 more cycles; sel then returns to 1 with a fresh 4-cycle dwell.
- **Pin.** Stimulus: assert `pin` at `dwell_cnt=2`. Required: sel frozen for 10 cycles. After `pin` drops, sel advances 2 cycles later. A `flash_req` while pinned is still honoured.
- **Mid-flash reset.** Stimulus: `RST` during FLASH. Required: next edge gives `flashing=0`, `disp_sel=0`, `disp_byte=0x00`.
- **Data tracking.** Stimulus: change the selected source byte 0x5A→0xA5 mid-dwell. Required: `disp_byte=0xA5` after exactly 1 cycle, and sel unchanged.

Source files
------------

// File: rtl/display_sched_if.sv
// Signal bundle between the debug sources and the display scheduler.
`default_nettype none
interface display_sched_if;
   logic [31:0] src_data;
   logic [3:0]  src_en;
   logic [3:0]  flash_req;
   logic        pin;
   logic [7:0]  disp_byte;
   logic [1:0]  disp_sel;
   logic        flashing;

   modport master (
      output src_data, src_en, flash_req, pin,
      input  disp_byte, disp_sel, flashing
   );

   modport slave (
      input  src_data, src_en, flash_req, pin,
      output disp_byte, disp_sel, flashing
   );
endinterface
`default_nettype wire

// File: rtl/display_sched.sv
// Shares the two-digit seven-segment display between four 8-bit debug sources:
// timed rotation over enabled sources, pin/freeze, and a one-shot flash override.
`default_nettype none
module display_sched #(
   parameter int DWELL = 12_000_000,
   parameter int FLASH = 6_000_000
) (
   input  logic            CLK,
   input  logic            RST,
   display_sched_if.slave  bus
);
   localparam int DW = $clog2(DWELL);
   localparam int FW = $clog2(FLASH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_FLASH  = 2'd2
   } state_t;

   state_t        state, nxt_state;
   logic [DW-1:0] dwell_cnt, nxt_dwell;
   logic [FW-1:0] flash_cnt, nxt_flash;
   logic [1:0]    rot_sel, nxt_rot;
   logic [1:0]    disp_sel, nxt_sel;
   logic [7:0]    disp_byte, nxt_byte;
   logic [3:0]    flash_lsb;

   // Circular search i+1, i+2, i+3; falls back to i when nothing else is enabled.
   function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] en);
      logic [1:0] r;
      logic [1:0] c;
      r = cur;
      for (int k = 3; k >= 1; k--) begin
         c = cur + 2'(k);
         if (en[c]) r = c;
      end
      return r;
   endfunction

   function automatic logic [1:0] lowest_idx(input logic [3:0] en);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (en[i]) r = 2'(i);
      end
      return r;
   endfunction

   assign flash_lsb = bus.flash_req & (~bus.flash_req + 4'd1);

   always_comb begin
      nxt_state = state;
      nxt_dwell = dwell_cnt;
      nxt_flash = flash_cnt;
      nxt_rot   = rot_sel;
      nxt_sel   = disp_sel;

      if (bus.flash_req != 4'd0) begin
         nxt_state = ST_FLASH;
         nxt_flash = '0;
         nxt_sel   = lowest_idx(flash_lsb);
         if (state == ST_ROTATE) nxt_rot = disp_sel;
      end else begin
         case (state)
            ST_FLASH: begin
               if (flash_cnt == FW'(FLASH - 1)) begin
                  nxt_flash = '0;
                  if (bus.src_en == 4'd0) begin
                     nxt_state = ST_IDLE;
                     nxt_dwell = '0;
                  end else begin
                     nxt_state = ST_ROTATE;
                     nxt_dwell = '0;
                     nxt_sel   = bus.src_en[rot_sel] ? rot_sel : next_idx(rot_sel, bus.src_en);
                  end
               end else begin
                  nxt_flash = flash_cnt + FW'(1);
               end
            end
            ST_ROTATE: begin
               if (bus.src_en == 4'd0) begin
                  nxt_state = ST_IDLE;
                  nxt_dwell = '0;
                  nxt_flash = '0;
               end else if (!bus.src_en[disp_sel]) begin
                  nxt_sel   = next_idx(disp_sel, bus.src_en);
                  nxt_dwell = '0;
               end else if (!bus.pin) begin
                  if (dwell_cnt == DW'(DWELL - 1)) begin
                     nxt_dwell = '0;
                     nxt_sel   = next_idx(disp_sel, bus.src_en);
                  end else begin
                     nxt_dwell = dwell_cnt + DW'(1);
                  end
               end
            end
            default: begin
               nxt_dwell = '0;
               nxt_flash = '0;
               if (bus.src_en != 4'd0) begin
                  nxt_state = ST_ROTATE;
                  nxt_sel   = lowest_idx(bus.src_en);
               end
            end
         endcase
      end

      // Byte is taken at the selection loaded on the same edge, so sel and byte never disagree.
      nxt_byte = (nxt_state == ST_IDLE) ? 8'h00 : bus.src_data[{nxt_sel, 3'b000} +: 8];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= (bus.src_en != 4'd0) ? ST_ROTATE : ST_IDLE;
         dwell_cnt <= '0;
         flash_cnt <= '0;
         rot_sel   <= 2'd0;
         disp_sel  <= 2'd0;
         disp_byte <= 8'h00;
      end else begin
         state     <= nxt_state;
         dwell_cnt <= nxt_dwell;
         flash_cnt <= nxt_flash;
         rot_sel   <= nxt_rot;
         disp_sel  <= nxt_sel;
         disp_byte <= nxt_byte;
      end
   end

   assign bus.disp_byte = disp_byte;
   assign bus.disp_sel  = disp_sel;
   assign bus.flashing  = (state == ST_FLASH);
endmodule
`default_nettype wire

// File: tb/tb_display_sched.sv
// Directed bench for display_sched with DWELL=4, FLASH=3.
`default_nettype none
module tb_display_sched;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   total = 0;
   int   bad = 0;

   display_sched_if dsif ();

   display_sched #(.DWELL(4), .FLASH(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (dsif)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      dsif.src_en = 4'b1111;
      dsif.src_data = 32'h44332211;
      dsif.flash_req = 4'b0000;
      dsif.pin = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      total++; if (dsif.disp_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", dsif.disp_sel); end
      total++; if (dsif.disp_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", dsif.disp_byte); end
      total++; if (dsif.flashing !== 1'b0) begin bad++; $display("FAIL reset_flashing got=%b exp=0", dsif.flashing); end
   endtask

   task automatic test_rotation();
      logic [1:0] es;
      logic [7:0] eb;
      for (int k = 1; k <= 19; k++) begin
         tick();
         es = 2'((k / 4) % 4);
         eb = 8'h11 * (8'(es) + 8'd1);
         total++; if (dsif.disp_sel !== es) begin bad++; $display("FAIL rot_sel k=%0d got=%0d exp=%0d", k, dsif.disp_sel, es); end
         total++; if (dsif.disp_byte !== eb) begin bad++; $display("FAIL rot_byte k=%0d got=%h exp=%h", k, dsif.disp_byte, eb); end
      end
   endtask

   task automatic test_skip_disable();
      logic [1:0] es;
      dsif.src_en = 4'b1010;
      for (int e = 1; e <= 6; e++) begin
         tick();
         es = (((e - 1) / 4) % 2 == 0) ? 2'd1 : 2'd3;
         total++; if (dsif.disp_sel !== es) begin bad++; $display("FAIL skip_sel e=%0d got=%0d exp=%0d", e, dsif.disp_sel, es); end
      end
      dsif.src_en = 4'b0010;
      tick();
      total++; if (dsif.disp_sel !== 2'd1) begin bad++; $display("FAIL disable_sel got=%0d exp=1", dsif.disp_sel); end
      total++; if (dsif.disp_byte !== 8'h22) begin bad++; $display("FAIL disable_byte got=%h exp=22", dsif.disp_byte); end
      dsif.src_en = 4'b0000;
      tick();
      total++; if (dsif.disp_byte !== 8'h00) begin bad++; $display("FAIL idle_byte got=%h exp=00", dsif.disp_byte); end
      total++; if (dsif.disp_sel !== 2'd1) begin bad++; $display("FAIL idle_sel got=%0d exp=1", dsif.disp_sel); end
   endtask

   task automatic test_flash_retrigger();
      dsif.src_en = 4'b0010;
      tick();
      total++; if (dsif.disp_sel !== 2'd1) begin bad++; $display("FAIL idle_exit_sel got=%0d exp=1", dsif.disp_sel); end
      dsif.src_en = 4'b1111;
      dsif.flash_req = 4'b1100;
      tick();
      total++; if (dsif.disp_sel !== 2'd2) begin bad++; $display("FAIL flash_sel got=%0d exp=2", dsif.disp_sel); end
      total++; if (dsif.flashing !== 1'b1) begin bad++; $display("FAIL flash_flag got=%b exp=1", dsif.flashing); end
      total++; if (dsif.disp_byte !== 8'h33) begin bad++; $display("FAIL flash_byte got=%h exp=33", dsif.disp_byte); end
      dsif.flash_req = 4'b0001;
      tick();
      dsif.flash_req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         total++; if (dsif.disp_sel !== 2'd0 || dsif.flashing !== 1'b1) begin bad++; $display("FAIL retrig_hold i=%0d sel=%0d flashing=%b exp sel=0 flashing=1", i, dsif.disp_sel, dsif.flashing); end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         total++; if (dsif.disp_sel !== 2'd1 || dsif.flashing !== 1'b0) begin bad++; $display("FAIL resume i=%0d sel=%0d flashing=%b exp sel=1 flashing=0", i, dsif.disp_sel, dsif.flashing); end
         tick();
      end
      total++; if (dsif.disp_sel !== 2'd2) begin bad++; $display("FAIL resume_adv got=%0d exp=2", dsif.disp_sel); end
   endtask

   task automatic test_pin();
      tick();
      tick();
      dsif.pin = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++; if (dsif.disp_sel !== 2'd2) begin bad++; $display("FAIL pin_hold i=%0d got=%0d exp=2", i, dsif.disp_sel); end
      end
      dsif.pin = 1'b0;
      tick();
      total++; if (dsif.disp_sel !== 2'd2) begin bad++; $display("FAIL unpin_1 got=%0d exp=2", dsif.disp_sel); end
      tick();
      total++; if (dsif.disp_sel !== 2'd3) begin bad++; $display("FAIL unpin_2 got=%0d exp=3", dsif.disp_sel); end
      dsif.pin = 1'b1;
      dsif.flash_req = 4'b0001;
      tick();
      dsif.flash_req = 4'b0000;
      total++; if (dsif.disp_sel !== 2'd0 || dsif.flashing !== 1'b1) begin bad++; $display("FAIL pin_flash sel=%0d flashing=%b exp sel=0 flashing=1", dsif.disp_sel, dsif.flashing); end
   endtask

   task automatic test_mid_flash_reset();
      tick();
      total++; if (dsif.flashing !== 1'b1) begin bad++; $display("FAIL still_flash got=%b exp=1", dsif.flashing); end
      RST = 1'b1;
      dsif.flash_req = 4'b0100;
      tick();
      RST = 1'b0;
      dsif.flash_req = 4'b0000;
      dsif.pin = 1'b0;
      total++; if (dsif.flashing !== 1'b0) begin bad++; $display("FAIL rst_flashing got=%b exp=0", dsif.flashing); end
      total++; if (dsif.disp_sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", dsif.disp_sel); end
      total++; if (dsif.disp_byte !== 8'h00) begin bad++; $display("FAIL rst_byte got=%h exp=00", dsif.disp_byte); end
   endtask

   task automatic test_data_tracking();
      dsif.src_data = 32'h4433225A;
      tick();
      total++; if (dsif.disp_byte !== 8'h5A) begin bad++; $display("FAIL track_5a got=%h exp=5a", dsif.disp_byte); end
      dsif.src_data = 32'h443322A5;
      tick();
      total++; if (dsif.disp_byte !== 8'hA5) begin bad++; $display("FAIL track_a5 got=%h exp=a5", dsif.disp_byte); end
      total++; if (dsif.disp_sel !== 2'd0) begin bad++; $display("FAIL track_sel got=%0d exp=0", dsif.disp_sel); end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_skip_disable();
      test_flash_retrigger();
      test_pin();
      test_mid_flash_reset();
      test_data_tracking();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
